// File: rtl/inv_meter_pkg.sv
// Shared types and defaults for the inverter delay meter.
package inv_meter_pkg;

    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned HOLD_CYC_DEF    = 16;
    localparam int unsigned TIMEOUT_DEF     = 255;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    localparam int unsigned NMEAS_W = 4;
    localparam int unsigned REM_W   = 5;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_HOLD,
        ST_DONE
    } state_e;

    // A burst length of zero encodes the maximum of 16 measurements.
    function automatic logic [REM_W-1:0] meas_total(input logic [NMEAS_W-1:0] n);
        return (n == '0) ? REM_W'(16) : REM_W'(n);
    endfunction

endpackage

// File: rtl/inv_delay_meter_resp_sync.sv
// N-stage synchroniser for the returned inverter output, with freeze on ena=0.
module resp_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = sync_q;
        if (ena) begin
            sync_d = {sync_q[STAGES-2:0], async_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/inv_delay_meter.sv
// Drives the analog inverter input, times each response in clk cycles and
// keeps min/max delay plus a sticky timeout flag over a burst.
module inv_delay_meter
    import inv_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic [NMEAS_W-1:0] n_meas,
    input  logic               resp_in,
    output logic               stim_out,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   delay_min,
    output logic [CNT_W-1:0]   delay_max
);

    state_e             state_q, state_d;
    logic               stim_q, stim_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               terr_q, terr_d;
    logic [CNT_W-1:0]   min_q, min_d;
    logic [CNT_W-1:0]   max_q, max_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               sync_resp;

    // Synchroniser idles at 1, the inverter output for stim_out=0.
    resp_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_resp_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .async_in (resp_in),
        .sync_out (sync_resp)
    );

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        terr_d  = terr_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        rem_d   = rem_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = meas_total(n_meas);
                    min_d   = '1;
                    max_d   = '0;
                    terr_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                stim_d  = ~stim_q;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // stim_q already holds the new level; a match wins over timeout.
                if (sync_resp == ~stim_q) begin
                    if (cnt_q < min_q) min_d = cnt_q;
                    if (cnt_q > max_q) max_d = cnt_q;
                    hold_d  = '0;
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    terr_d  = 1'b1;
                    hold_d  = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stim_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            min_q   <= '1;
            max_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            rem_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rem_q   <= rem_d;
        end
    end

    assign stim_out    = stim_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign delay_min   = min_q;
    assign delay_max   = max_q;

endmodule

// File: tb/tb_inv_delay_meter.sv
// Scoreboard bench for inv_delay_meter with a behavioural inverter model.
module tb_inv_delay_meter;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned HOLD_CYC = 16;
    localparam int unsigned TIMEOUT  = 255;
    localparam int unsigned SYNC     = 2;

    localparam int MODE_LOOP  = 0;
    localparam int MODE_DELAY = 1;
    localparam int MODE_STUCK = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             start;
    logic [3:0]       n_meas;
    logic             resp_in;
    logic             stim_out;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [CNT_W-1:0] delay_min;
    logic [CNT_W-1:0] delay_max;

    typedef struct {
        logic [CNT_W-1:0] mn;
        logic [CNT_W-1:0] mx;
        logic             terr;
        int               toggles;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Inverter model controls (written only while the DUT is idle).
    int   mode    = MODE_LOOP;
    logic stuck_v = 1'b1;
    int   dly[2]  = '{3, 7};
    logic model_stim = 1'b0;

    inv_delay_meter #(
        .CNT_W       (CNT_W),
        .HOLD_CYC    (HOLD_CYC),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start),
        .n_meas      (n_meas),
        .resp_in     (resp_in),
        .stim_out    (stim_out),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .delay_min   (delay_min),
        .delay_max   (delay_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Behavioural inverter: responds a whole number of clk cycles after each stim edge.
    logic last_stim = 1'b0;
    logic target    = 1'b1;
    int   cd        = 0;
    int   k         = 0;
    initial resp_in = 1'b1;
    always @(posedge clk) begin
        logic changed;
        #1;
        changed = (stim_out !== last_stim);
        last_stim = stim_out;
        if (mode == MODE_LOOP) begin
            resp_in = ~stim_out;
            k  = 0;
            cd = 0;
        end else if (mode == MODE_STUCK) begin
            resp_in = stuck_v;
            k  = 0;
            cd = 0;
        end else if (changed) begin
            target = ~stim_out;
            cd     = dly[k % 2];
            k++;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) resp_in = target;
        end
    end

    // Reference model: per-measurement delay from the inverter behaviour plus sync latency.
    function automatic exp_t model(input int md, input logic v, input int d0, input int d1,
                                   input logic s0, input logic [3:0] n);
        exp_t e;
        int   total;
        int   c;
        logic s;
        total = (n == 4'd0) ? 16 : int'(n);
        s = s0;
        e.mn = '1;
        e.mx = '0;
        e.terr = 1'b0;
        e.toggles = total;
        for (int i = 0; i < total; i++) begin
            s = ~s;
            if (md == MODE_LOOP)       c = int'(SYNC);
            else if (md == MODE_DELAY) c = ((i % 2) == 0 ? d0 : d1) + int'(SYNC);
            else                       c = (v == ~s) ? 0 : int'(TIMEOUT) + 1;
            if (c > int'(TIMEOUT)) begin
                e.terr = 1'b1;
            end else begin
                if (CNT_W'(c) < e.mn) e.mn = CNT_W'(c);
                if (CNT_W'(c) > e.mx) e.mx = CNT_W'(c);
            end
        end
        return e;
    endfunction

    // Monitor: counts stim edges and checks each done pulse against the scoreboard.
    int   toggles   = 0;
    logic prev_stim = 1'b0;
    logic rst_seen  = 1'b1;
    always @(negedge clk) begin
        if (!rst_n || rst_seen) begin
            toggles   = 0;
            prev_stim = stim_out;
        end else begin
            if (stim_out !== prev_stim) toggles++;
            prev_stim = stim_out;
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("delay_min", 32'(delay_min), 32'(e.mn));
                    check("delay_max", 32'(delay_max), 32'(e.mx));
                    check("timeout_err", 32'(timeout_err), 32'(e.terr));
                    check("toggle_count", 32'(toggles), 32'(e.toggles));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
                toggles = 0;
            end
        end
        rst_seen = !rst_n;
    end

    task automatic wait_edges(input int n, input string name);
        int   seen = 0;
        int   cyc  = 0;
        logic p;
        p = stim_out;
        while (seen < n && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (stim_out !== p) seen++;
            p = stim_out;
        end
        if (seen < n) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_empty(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            check(name, 32'd0, 32'd1);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic set_mode(input int md);
        mode = MODE_LOOP;
        repeat (2) @(posedge clk);
        #1;
        mode = md;
    endtask

    task automatic run_burst(input logic [3:0] n, input bit extra_start, input bit ena_pause);
        exp_t e;
        e = model(mode, stuck_v, dly[0], dly[1], model_stim, n);
        model_stim = model_stim ^ e.toggles[0];
        n_meas = n;
        exp_q.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        if (ena_pause) begin
            wait_edges(1, "ena_first_edge");
            ena = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            ena = 1'b1;
        end
        if (extra_start) begin
            repeat (30) @(posedge clk);
            #1;
            start = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_empty("burst_done_timeout");
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        start  = 1'b0;
        n_meas = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_stim", 32'(stim_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_min", 32'(delay_min), 32'hFF);
        check("rst_max", 32'(delay_max), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        set_mode(MODE_LOOP);
        run_burst(4'd4, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("idle_after_extra_start", 32'(busy), 32'd0);

        dly[0] = 3; dly[1] = 7;
        set_mode(MODE_DELAY);
        run_burst(4'd6, 1'b0, 1'b0);

        stuck_v = 1'b1;
        set_mode(MODE_STUCK);
        run_burst(4'd1, 1'b0, 1'b0);
        run_burst(4'd2, 1'b0, 1'b0);

        set_mode(MODE_LOOP);
        run_burst(4'd0, 1'b0, 1'b0);
        run_burst(4'd1, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            dly[0] = int'($urandom_range(1, 12));
            dly[1] = int'($urandom_range(1, 12));
            set_mode(MODE_DELAY);
            run_burst(4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end

        // Reset during the second measurement's WAIT.
        set_mode(MODE_LOOP);
        n_meas = 4'd4;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_edges(2, "reset_test_edges");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_stim", 32'(stim_out), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_terr", 32'(timeout_err), 32'd0);
        check("midrst_min", 32'(delay_min), 32'hFF);
        check("midrst_max", 32'(delay_max), 32'd0);
        model_stim = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("midrst_still_idle", 32'(busy), 32'd0);

        run_burst(4'd3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
